clint_mmio: RTL

Memory-mapped core-local interruptor that answers CPU data-bus requests and drives the machine software and timer interrupt inputs of `cpu`. It responds to the same `ren`/`wen`/`byte_select`/`memReady` request protocol the CPU issues toward the memory management units. It holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` bit. It sits on the data bus beside `memory_management_unit_d`, selected by address window.

---
 rtl/clint_mmio.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/clint_mmio.sv
// Core-local interruptor on the CPU data bus: msip, 64-bit mtime/mtimecmp and
// the machine software/timer interrupt lines, behind a 3-cycle request FSM.
module clint_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic        ren,
    input  logic [3:0]  byte_select,
    output logic [31:0] rdata,
    output logic        memReady,
    output logic        hit,
    output logic        msw_irq,
    output logic        mtimer_irq
);
    localparam int unsigned   PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    // Word offsets (addr[15:2]) of the mapped registers
    localparam logic [13:0] OFF_MSIP  = 14'h0000;
    localparam logic [13:0] OFF_CMPLO = 14'h1000;
    localparam logic [13:0] OFF_CMPHI = 14'h1001;
    localparam logic [13:0] OFF_MTLO  = 14'h2FFE;
    localparam logic [13:0] OFF_MTHI  = 14'h2FFF;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e        state_q, state_d;
    logic [13:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          msip_q, msip_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tirq_q, tirq_d;

    logic          commit, tick;
    logic [31:0]   bmask, rd_word;

    logic unused_bits;
    assign unused_bits = &{1'b0, addr[1:0]};

    assign hit        = (ren | wen) && (addr[31:16] == BASE_ADDR[31:16]);
    assign memReady   = (state_q == RESP);
    assign rdata      = rdata_q;
    assign msw_irq    = msip_q;
    assign mtimer_irq = tirq_q;

    assign commit = (state_q == BUSY) && wr_q;
    assign tick   = (presc_q == PS_MAX);
    assign bmask  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [31:0] m);
        return (old & ~m) | (nw & m);
    endfunction

    always_comb begin
        rd_word = 32'h0;
        case (addr_q)
            OFF_MSIP:  rd_word = {31'h0, msip_q};
            OFF_CMPLO: rd_word = mtimecmp_q[31:0];
            OFF_CMPHI: rd_word = mtimecmp_q[63:32];
            OFF_MTLO:  rd_word = mtime_q[31:0];
            OFF_MTHI:  rd_word = mtime_q[63:32];
            default:   rd_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (hit) begin
                state_d = BUSY;
                addr_d  = addr[15:2];
                wdata_d = wdata;
                be_d    = byte_select;
                wr_d    = wen;      // wen wins over a simultaneous ren
            end
            BUSY: begin
                state_d = RESP;
                if (!wr_q) rdata_d = rd_word;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        if (commit) begin
            case (addr_q)
                OFF_MSIP:  if (be_q[0]) msip_d = wdata_q[0];
                OFF_CMPLO: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata_q, bmask);
                OFF_CMPHI: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata_q, bmask);
                // A software write replaces the whole counter, so that edge's tick is lost
                OFF_MTLO:  mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata_q, bmask)};
                OFF_MTHI:  mtime_d = {merge(mtime_q[63:32], wdata_q, bmask), mtime_q[31:0]};
                default: ;
            endcase
        end
        tirq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            tirq_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            tirq_q     <= tirq_d;
        end
    end
endmodule
